button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 23 ++
 rtl/button_channel.sv | 143 ++++++++++++++
 rtl/button_conditioner.sv | 51 +++++
 tb/tb_button_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the button conditioner.
// The BUTTON_AUTO_REPEAT_EN macro enables held-key auto-repeat in button_channel.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 10 ms debounce, 500 ms first repeat, 200 ms repeat period at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, held flag, event pulse.
// With BUTTON_AUTO_REPEAT_EN defined, HELD also emits timed repeat pulses.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    // All counters share one width, wide enough for the largest timing value.
    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // The inversion to active-high is folded into the first flop so that the
    // cleared (zero) synchronizer reads as "released" and a key held across
    // reset is debounced from scratch.
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] deb_cnt_inc;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;
    logic             pressed;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_inc;
    logic             rpt_periodic_q, rpt_periodic_d;
`endif

    assign pressed = sync2_q;
    assign pulse   = pulse_q;
    assign held    = held_q;

    // Next-state logic for synchronizer, debounce FSM, counters and outputs.
    always_comb begin
        sync1_d     = ~key_n;
        sync2_d     = sync1_q;
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        pulse_d     = 1'b0;
        deb_cnt_inc = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + CNT_ONE;
`ifdef BUTTON_AUTO_REPEAT_EN
        rpt_cnt_d      = rpt_cnt_q;
        rpt_periodic_d = rpt_periodic_q;
        rpt_cnt_inc    = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + CNT_ONE;
`endif
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_inc == DEB_TARGET) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                    pulse_d   = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                    rpt_cnt_d      = '0;
                    rpt_periodic_d = 1'b0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_inc;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = CNT_ONE;
`ifdef BUTTON_AUTO_REPEAT_EN
                end else if (rpt_cnt_inc == (rpt_periodic_q ? RPT_NEXT : RPT_FIRST)) begin
                    rpt_cnt_d      = '0;
                    rpt_periodic_d = 1'b1;
                    pulse_d        = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_inc;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_inc == DEB_TARGET) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    // Register all channel state; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            pulse_q   <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_q      <= '0;
            rpt_periodic_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            pulse_q   <= pulse_d;
            held_q    <= held_d;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_q      <= rpt_cnt_d;
            rpt_periodic_q <= rpt_periodic_d;
`endif
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Two debounced button channels (increment, decrement) with conflict suppression.
// Define BUTTON_AUTO_REPEAT_EN to enable auto-repeat in both channels.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_key_n,
    input  logic dec_key_n,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held
);

    logic inc_event;
    logic dec_event;

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_inc (
        .clk  (clk),
        .reset(reset),
        .key_n(inc_key_n),
        .pulse(inc_event),
        .held (inc_held)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_dec (
        .clk  (clk),
        .reset(reset),
        .key_n(dec_key_n),
        .pulse(dec_event),
        .held (dec_held)
    );

    // Contradictory simultaneous events cancel each other; held flags are untouched.
    assign inc_pulse = inc_event & ~dec_event;
    assign dec_pulse = dec_event & ~inc_event;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Repeat expectations follow BUTTON_AUTO_REPEAT_EN.
module tb_button_conditioner;

    logic clk;
    logic reset;
    logic inc_key_n;
    logic dec_key_n;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_held;
    logic dec_held;

    int checks;
    int errors;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inc_key_n(inc_key_n),
        .dec_key_n(dec_key_n),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .inc_held (inc_held),
        .dec_held (dec_held)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled and inputs driven 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release both keys and give the channels time to settle back to IDLE
    task automatic release_all();
        inc_key_n = 1'b1;
        dec_key_n = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        inc_key_n = 1'b1;
        dec_key_n = 1'b1;
        tick();
        tick();
        checks++;
        if (inc_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_inc_pulse got %b expected 0", inc_pulse); end
        checks++;
        if (dec_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_dec_pulse got %b expected 0", dec_pulse); end
        checks++;
        if (inc_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_inc_held got %b expected 0", inc_held); end
        checks++;
        if (dec_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_dec_held got %b expected 0", dec_held); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clean_press();
        inc_key_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (inc_pulse !== (c == 6)) begin errors++; $display("[TB] FAIL press_pulse cycle %0d got %b expected %b", c, inc_pulse, (c == 6)); end
            checks++;
            if (inc_held !== (c >= 6)) begin errors++; $display("[TB] FAIL press_held cycle %0d got %b expected %b", c, inc_held, (c >= 6)); end
        end
        inc_key_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (inc_pulse !== 1'b0) begin errors++; $display("[TB] FAIL release_pulse cycle %0d got %b expected 0", c, inc_pulse); end
            checks++;
            if (inc_held !== (c < 6)) begin errors++; $display("[TB] FAIL release_held cycle %0d got %b expected %b", c, inc_held, (c < 6)); end
        end
        release_all();
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            inc_key_n = (((c / 2) % 2) == 1);
            tick();
            checks++;
            if (inc_pulse !== 1'b0 || inc_held !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bounce_quiet cycle %0d got pulse=%b held=%b expected 0/0", c + 1, inc_pulse, inc_held);
            end
        end
        inc_key_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (inc_pulse !== (k == 6)) begin errors++; $display("[TB] FAIL bounce_pulse +%0d got %b expected %b", k, inc_pulse, (k == 6)); end
        end
        release_all();
    endtask

    task automatic test_simultaneous();
        inc_key_n = 1'b0;
        dec_key_n = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
                errors++;
                $display("[TB] FAIL simul_pulses cycle %0d got inc=%b dec=%b expected 0/0", c, inc_pulse, dec_pulse);
            end
            checks++;
            if (inc_held !== (c >= 6) || dec_held !== (c >= 6)) begin
                errors++;
                $display("[TB] FAIL simul_held cycle %0d got inc=%b dec=%b expected %b/%b", c, inc_held, dec_held, (c >= 6), (c >= 6));
            end
        end
        release_all();
    endtask

    task automatic test_release_glitch();
        dec_key_n = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (dec_pulse !== (c == 6)) begin errors++; $display("[TB] FAIL glitch_first_pulse cycle %0d got %b expected %b", c, dec_pulse, (c == 6)); end
        end
        dec_key_n = 1'b1;
        tick();
        dec_key_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (dec_held !== 1'b1 || dec_pulse !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch_hold cycle %0d got held=%b pulse=%b expected 1/0", c, dec_held, dec_pulse);
            end
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        inc_key_n = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({inc_pulse, dec_pulse, inc_held, dec_held} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs got %b expected 0000", {inc_pulse, dec_pulse, inc_held, dec_held});
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (inc_pulse !== (k == 6)) begin errors++; $display("[TB] FAIL reset_mid_pulse +%0d got %b expected %b", k, inc_pulse, (k == 6)); end
            checks++;
            if (inc_held !== (k >= 6)) begin errors++; $display("[TB] FAIL reset_mid_held +%0d got %b expected %b", k, inc_held, (k >= 6)); end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (inc_held !== 1'b0 || inc_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_from_held got held=%b pulse=%b expected 0/0", inc_held, inc_pulse);
        end
        reset = 1'b0;
        release_all();
    endtask

    task automatic test_long_hold();
        logic expected;
        inc_key_n = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            if (c == 61) inc_key_n = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            expected = (c == 6) || (c == 26) || (c == 34) || (c == 42) || (c == 50) || (c == 58);
`else
            expected = (c == 6);
`endif
            tick();
            checks++;
            if (inc_pulse !== expected) begin errors++; $display("[TB] FAIL long_hold_pulse cycle %0d got %b expected %b", c, inc_pulse, expected); end
        end
        release_all();
    endtask

    // Run every scenario in order, then report
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        inc_key_n = 1'b1;
        dec_key_n = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_glitch();
        test_reset_mid();
        test_long_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
